decoder_rr_arbiter: RTL and testbench

//  8-requester round-robin arbiter that shares one 3:8 decoded resource slot.

---
 rtl/decoder_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/decoder_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared constants and helpers for the 8-way round-robin decoder arbiter.
// Holds the requester count, index width, FSM encoding and the 3:8 decode.
package decoder_arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] dec8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ...
// wrapping 7->0. Purely combinational.
module rr_pick
    import decoder_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the far end so the lowest offset from ptr is written last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with registered index and one-hot decoded grant.
// Define ARB_TIMEOUT_EN to force-revoke grants held longer than HOLD_MAX.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    logic             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             to_q, to_d;
    logic             any;
    logic [IDX_W-1:0] pick_idx;
    logic             held;
    logic             expire;
    logic             drop;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (any),
        .idx (pick_idx)
    );

    assign held = req[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The grant edge loads 1, so HOLD_MAX visible cycles end on this compare.
    assign expire = (cnt_q == CNT_W'(HOLD_MAX));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_IDLE && any)
            cnt_d = CNT_W'(1);
        else if (state_q == ST_GRANT && !drop)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    assign drop = !held || expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any)  state_d = ST_GRANT;
            ST_GRANT: if (drop) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                valid_d = any;
                idx_d   = any ? pick_idx : '0;
            end
            ST_GRANT: begin
                if (drop) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    to_d    = expire && held;
                end
            end
        endcase
        gnt_d = valid_d ? dec8(idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: reset, rotation, wrap,
// no-preemption, async reset mid-grant and optional timeout revoke.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
`else
    decoder_rr_arbiter dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected one-hot built independently of the DUT's decode.
    task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                           input logic to);
        logic [7:0] eg;
        eg = 8'h00;
        if (v) eg = 8'h01 << idx;
        chk({tag, ".gnt"},     {24'h0, gnt},     {24'h0, eg});
        chk({tag, ".idx"},     {29'h0, gnt_idx}, {29'h0, (v ? idx : 3'd0)});
        chk({tag, ".valid"},   {31'h0, gnt_valid}, {31'h0, v});
        chk({tag, ".timeout"}, {31'h0, timeout}, {31'h0, to});
    endtask

    initial begin
        // Reset with everyone requesting
        rst_n = 1'b0;
        req   = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk_out("rst", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("rst_first", 1'b1, 3'd0, 1'b0);

        // Rotation 0..7 then back to 0, one bubble between grants
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("rot%0d_g", k), 1'b1, 3'(k), 1'b0);
            tick();
            chk_out($sformatf("rot%0d_h", k), 1'b1, 3'(k), 1'b0);
            req = 8'hFF & ~(8'h01 << k);
            tick();
            chk_out($sformatf("rot%0d_b", k), 1'b0, 3'd0, 1'b0);
            req = 8'hFF;
            tick();
        end
        chk_out("rot_wrap", 1'b1, 3'd0, 1'b0);

        // Wrap: set ptr=6 via a grant to 5, then pick from {0,1}
        req = 8'h00;
        tick();
        chk_out("idle", 1'b0, 3'd0, 1'b0);
        req = 8'h20;
        tick();
        chk_out("wrap_g5", 1'b1, 3'd5, 1'b0);
        req = 8'h00;
        tick();
        req = 8'h03;
        tick();
        chk_out("wrap_g0", 1'b1, 3'd0, 1'b0);
        req = 8'h02;
        tick();
        chk_out("wrap_bub", 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("wrap_g1", 1'b1, 3'd1, 1'b0);
        req = 8'h00;
        tick();
        req = 8'h80;
        tick();
        chk_out("wrap_g7", 1'b1, 3'd7, 1'b0);
        req = 8'h00;
        tick();
        req = 8'hFF;
        tick();
        chk_out("wrap_ptr0", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        tick();

        // No preemption: hold 2 while 5 asks (ptr now 1)
        req = 8'h04;
        tick();
        chk_out("np_g2", 1'b1, 3'd2, 1'b0);
        req = 8'h24;
        tick();
        chk_out("np_hold1", 1'b1, 3'd2, 1'b0);
        tick();
        chk_out("np_hold2", 1'b1, 3'd2, 1'b0);
        req = 8'h20;
        tick();
        chk_out("np_bub", 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("np_g5", 1'b1, 3'd5, 1'b0);

        // Async reset between edges while granting 5 (ptr=3 at this point)
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        req   = 8'h80;
        rst_n = 1'b1;
        tick();
        chk_out("arst_g7", 1'b1, 3'd7, 1'b0);
        req = 8'h00;
        tick();
        // ptr=0 after the wrap from 7; a stale ptr of 3 would pick 6
        req = 8'h41;
        tick();
        chk_out("arst_ptr", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        tick();

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4, ptr=1: sole holder 3 revoked after 4 grant cycles
        req = 8'h08;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk_out($sformatf("to_h%0d", c), 1'b1, 3'd3, 1'b0);
            if (c < 3) tick();
        end
        tick();
        chk_out("to_pulse", 1'b0, 3'd0, 1'b1);
        tick();
        chk_out("to_regrant", 1'b1, 3'd3, 1'b0);
        req = 8'h18;
        repeat (4) tick();
        chk_out("to_pulse2", 1'b0, 3'd0, 1'b1);
        tick();
        chk_out("to_next4", 1'b1, 3'd4, 1'b0);
`else
        // Without the timeout a lone holder keeps its grant indefinitely
        req = 8'h08;
        tick();
        chk_out("hold_g3", 1'b1, 3'd3, 1'b0);
        repeat (20) tick();
        chk_out("hold_long", 1'b1, 3'd3, 1'b0);
        req = 8'h18;
        tick();
        chk_out("hold_np", 1'b1, 3'd3, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
